// File: rtl/quad_step_decoder_if.sv
// rtl/quad_step_decoder_if.sv - pin-side and counter-side signals of the quadrature step decoder
interface quad_step_decoder_if;
    logic en;
    logic enc_a;
    logic enc_b;
    logic step;
    logic updown;
    logic err;

    modport master (
        output en,
        output enc_a,
        output enc_b,
        input  step,
        input  updown,
        input  err
    );

    modport slave (
        input  en,
        input  enc_a,
        input  enc_b,
        output step,
        output updown,
        output err
    );
endinterface

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - synchronised, debounced quadrature decoder producing step/updown; optional err via QDEC_ERR_EN
module quad_step_decoder #(
    parameter int DB_CYCLES      = 4,
    parameter int DB_W           = 3,
    parameter int EDGES_PER_STEP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    quad_step_decoder_if.slave   bus
);

    typedef enum logic {INIT, TRACK} state_t;

    localparam logic signed [2:0] ACC_MAX  = 3'(EDGES_PER_STEP - 1);
    localparam logic signed [2:0] ACC_MIN  = -ACC_MAX;
    localparam logic [DB_W-1:0]   CNT_LAST = DB_W'(DB_CYCLES - 1);

    state_t              state_q, state_d;
    logic [1:0]          ab_s1, ab_s, ab_prev;
    logic [1:0]          ab_f, ab_f_d;
    logic [DB_W-1:0]     cnt, cnt_d;
    logic signed [2:0]   acc, acc_d;
    logic                step_q, step_d;
    logic                updown_q, updown_d;
    logic                stable, differs, accept;
    logic                fwd, bwd, illegal;

    function automatic logic [1:0] gray_next(input logic [1:0] v);
        case (v)
            2'b00:   gray_next = 2'b01;
            2'b01:   gray_next = 2'b11;
            2'b11:   gray_next = 2'b10;
            default: gray_next = 2'b00;
        endcase
    endfunction

    // In INIT the reset value of ab_f must not mask a stable 00, so any stable value is accepted.
    assign stable  = (ab_s == ab_prev);
    assign differs = (state_q == INIT) || (ab_s != ab_f);
    assign accept  = stable && differs && (cnt == CNT_LAST);

    assign fwd     = (gray_next(ab_f) == ab_s);
    assign bwd     = (gray_next(ab_s) == ab_f);
    assign illegal = ((ab_f ^ ab_s) == 2'b11);

`ifdef QDEC_ERR_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        ab_f_d   = ab_f;
        cnt_d    = cnt;
        acc_d    = acc;
        step_d   = 1'b0;
        updown_d = updown_q;
`ifdef QDEC_ERR_EN
        err_d    = 1'b0;
`endif
        if (!stable || !differs || accept)
            cnt_d = '0;
        else
            cnt_d = cnt + 1'b1;

        if (accept) begin
            ab_f_d = ab_s;
            if (state_q == INIT) begin
                state_d = TRACK;
            end else if (illegal) begin
                acc_d = '0;
`ifdef QDEC_ERR_EN
                err_d = 1'b1;
`endif
            end else if (fwd && bus.en) begin
                if (acc == ACC_MAX) begin
                    step_d   = 1'b1;
                    updown_d = 1'b1;
                    acc_d    = '0;
                end else begin
                    acc_d = acc + 3'sd1;
                end
            end else if (bwd && bus.en) begin
                if (acc == ACC_MIN) begin
                    step_d   = 1'b1;
                    updown_d = 1'b0;
                    acc_d    = '0;
                end else begin
                    acc_d = acc - 3'sd1;
                end
            end
        end

        // Holding acc at zero while disabled is what prevents a burst on re-enable.
        if (!bus.en)
            acc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= INIT;
            ab_s1    <= 2'b00;
            ab_s     <= 2'b00;
            ab_prev  <= 2'b00;
            ab_f     <= 2'b00;
            cnt      <= '0;
            acc      <= '0;
            step_q   <= 1'b0;
            updown_q <= 1'b1;
`ifdef QDEC_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ab_s1    <= {bus.enc_a, bus.enc_b};
            ab_s     <= ab_s1;
            ab_prev  <= ab_s;
            ab_f     <= ab_f_d;
            cnt      <= cnt_d;
            acc      <= acc_d;
            step_q   <= step_d;
            updown_q <= updown_d;
`ifdef QDEC_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    assign bus.step   = step_q;
    assign bus.updown = updown_q;
`ifdef QDEC_ERR_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - table-driven check of quad_step_decoder at EDGES_PER_STEP 4, 2 and 1
module tb_quad_step_decoder;

`ifdef QDEC_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic clk;
    logic reset;
    logic en, pa, pb;

    quad_step_decoder_if q4 ();
    quad_step_decoder_if q2 ();
    quad_step_decoder_if q1 ();

    assign q4.en = en; assign q4.enc_a = pa; assign q4.enc_b = pb;
    assign q2.en = en; assign q2.enc_a = pa; assign q2.enc_b = pb;
    assign q1.en = en; assign q1.enc_a = pa; assign q1.enc_b = pb;

    quad_step_decoder #(.DB_CYCLES(4), .DB_W(3), .EDGES_PER_STEP(4)) dut  (.clk(clk), .reset(reset), .bus(q4));
    quad_step_decoder #(.DB_CYCLES(4), .DB_W(3), .EDGES_PER_STEP(2)) dut2 (.clk(clk), .reset(reset), .bus(q2));
    quad_step_decoder #(.DB_CYCLES(4), .DB_W(3), .EDGES_PER_STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(q1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int s4 = 0, s2 = 0, s1 = 0, e4 = 0, dbl = 0;
    logic prev4 = 1'b0;

    always @(negedge clk) begin
        if (q4.step) s4 <= s4 + 1;
        if (q2.step) s2 <= s2 + 1;
        if (q1.step) s1 <= s1 + 1;
        if (q4.err)  e4 <= e4 + 1;
        if (q4.step && prev4) dbl <= dbl + 1;
        prev4 <= q4.step;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ab, input int hold, input logic e);
        pa = ab[1];
        pb = ab[0];
        en = e;
        repeat (hold) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] ab;
        int         hold;
        logic       en;
        int         s4, s2, s1;
        logic       ud;
        int         ill;
    } vec_t;

    vec_t tbl[29];
    int b4, b2, b1, be, lat, snap;

    initial begin
        // Cumulative step counts per decoder, updown of the E=4 decoder, illegal edges so far.
        tbl[0]  = '{2'b01, 8, 1'b1, 0,  0,  1, 1'b1, 0};
        tbl[1]  = '{2'b11, 8, 1'b1, 0,  1,  2, 1'b1, 0};
        tbl[2]  = '{2'b10, 8, 1'b1, 0,  1,  3, 1'b1, 0};
        tbl[3]  = '{2'b00, 8, 1'b1, 1,  2,  4, 1'b1, 0};
        tbl[4]  = '{2'b10, 8, 1'b1, 1,  2,  5, 1'b1, 0};
        tbl[5]  = '{2'b11, 8, 1'b1, 1,  3,  6, 1'b1, 0};
        tbl[6]  = '{2'b01, 8, 1'b1, 1,  3,  7, 1'b1, 0};
        tbl[7]  = '{2'b00, 8, 1'b1, 2,  4,  8, 1'b0, 0};
        tbl[8]  = '{2'b01, 8, 1'b1, 2,  4,  9, 1'b0, 0};
        tbl[9]  = '{2'b11, 8, 1'b1, 2,  5, 10, 1'b0, 0};
        tbl[10] = '{2'b01, 8, 1'b1, 2,  5, 11, 1'b0, 0};
        tbl[11] = '{2'b00, 8, 1'b1, 2,  6, 12, 1'b0, 0};
        tbl[12] = '{2'b01, 2, 1'b1, 2,  6, 12, 1'b0, 0};
        tbl[13] = '{2'b00, 8, 1'b1, 2,  6, 12, 1'b0, 0};
        tbl[14] = '{2'b11, 8, 1'b1, 2,  6, 12, 1'b0, 1};
        tbl[15] = '{2'b10, 8, 1'b1, 2,  6, 13, 1'b0, 1};
        tbl[16] = '{2'b00, 8, 1'b1, 2,  7, 14, 1'b0, 1};
        tbl[17] = '{2'b01, 8, 1'b1, 2,  7, 15, 1'b0, 1};
        tbl[18] = '{2'b11, 8, 1'b1, 3,  8, 16, 1'b1, 1};
        tbl[19] = '{2'b01, 8, 1'b1, 3,  8, 17, 1'b1, 1};
        tbl[20] = '{2'b00, 8, 1'b1, 3,  9, 18, 1'b1, 1};
        tbl[21] = '{2'b10, 8, 1'b1, 3,  9, 19, 1'b1, 1};
        tbl[22] = '{2'b11, 8, 1'b1, 4, 10, 20, 1'b0, 1};
        tbl[23] = '{2'b10, 8, 1'b0, 4, 10, 20, 1'b0, 1};
        tbl[24] = '{2'b00, 8, 1'b0, 4, 10, 20, 1'b0, 1};
        tbl[25] = '{2'b01, 8, 1'b0, 4, 10, 20, 1'b0, 1};
        tbl[26] = '{2'b11, 8, 1'b0, 4, 10, 20, 1'b0, 1};
        tbl[27] = '{2'b11, 8, 1'b1, 4, 10, 20, 1'b0, 1};
        tbl[28] = '{2'b10, 8, 1'b1, 4, 10, 21, 1'b0, 1};

        reset = 1'b1;
        en = 1'b1; pa = 1'b1; pb = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_step",   int'(q4.step),      0);
        chk("reset_updown", int'(q4.updown),    1);
        chk("reset_err",    int'(q4.err),       0);
        chk("reset_state",  int'(dut.state_q),  0);

        reset = 1'b0;
        drive(2'b11, 20, 1'b1);
        chk("init11_steps", s4, 0);
        chk("init11_err",   e4, 0);
        chk("init11_state", int'(dut.state_q), 1);
        chk("init11_abf",   int'(dut.ab_f),    3);

        reset = 1'b1;
        drive(2'b00, 3, 1'b1);
        reset = 1'b0;
        drive(2'b00, 12, 1'b1);
        chk("init00_state", int'(dut.state_q), 1);
        chk("init00_abf",   int'(dut.ab_f),    0);
        b4 = s4; b2 = s2; b1 = s1; be = e4;

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].ab, tbl[i].hold, tbl[i].en);
            chk($sformatf("v%0d_steps_e4", i), s4 - b4, tbl[i].s4);
            chk($sformatf("v%0d_steps_e2", i), s2 - b2, tbl[i].s2);
            chk($sformatf("v%0d_steps_e1", i), s1 - b1, tbl[i].s1);
            chk($sformatf("v%0d_updown", i),   int'(q4.updown), int'(tbl[i].ud));
            chk($sformatf("v%0d_errs", i),     e4 - be, tbl[i].ill * ERR_EN);
            if (i == 12 || i == 13)
                chk($sformatf("v%0d_glitch_abf", i), int'(dut.ab_f), 0);
        end

        drive(2'b00, 8, 1'b1);
        drive(2'b01, 3, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_step",   int'(q4.step),     0);
        chk("midreset_updown", int'(q4.updown),   1);
        chk("midreset_err",    int'(q4.err),      0);
        chk("midreset_state",  int'(dut.state_q), 0);
        chk("midreset_acc",    int'(dut.acc),     0);
        @(negedge clk);
        #1;
        snap = s4;
        reset = 1'b0;
        drive(2'b01, 12, 1'b1);
        chk("postreset_steps", s4 - snap, 0);
        chk("postreset_state", int'(dut.state_q), 1);
        chk("postreset_abf",   int'(dut.ab_f),    1);

        drive(2'b11, 8, 1'b1);
        drive(2'b10, 8, 1'b1);
        drive(2'b00, 8, 1'b1);
        chk("pre_latency_steps", s4 - snap, 0);
        pa = 1'b0; pb = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            if (q4.step && lat == 0) lat = k;
        end
        chk("latency_negedges", lat, 7);
        chk("latency_steps",    s4 - snap, 1);
        chk("latency_updown",   int'(q4.updown), 1);
        chk("no_double_step",   dbl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
